// File: rtl/fb_byte_writer_pkg.sv
// Shared definitions for the framebuffer byte writer: FSM states, strobe polarity, geometry.
package fb_byte_writer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_NEXT  = 2'd3
  } state_t;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  localparam int WAIT_W           = 4;
  localparam int PANEL_W_PX       = 800;
  localparam int PANEL_H_PX       = 600;
  localparam int PX_PER_BYTE      = 4;
  localparam int FB_WORDS_DEFAULT = PANEL_W_PX * PANEL_H_PX / PX_PER_BYTE;

  // Hold counters count down to zero, so a hold of N cycles loads N-1.
  function automatic logic [WAIT_W-1:0] wait_load(input int cycles);
    return WAIT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/fb_wait_counter.sv
// Load/decrement hold counter; term is high while the count sits at zero.
module fb_wait_counter
  import fb_byte_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              term
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WAIT_W'(1);
    end
  end

  assign term = (cnt == '0);

endmodule

// File: rtl/fb_byte_writer.sv
// SPI-to-SRAM framebuffer write engine. Define PREV_FRAME_EN to keep the previous frame in
// bits [15:8] via read-modify-write; otherwise each word is written as {8'h00, byte}.
module fb_byte_writer
  import fb_byte_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int FB_WORDS   = FB_WORDS_DEFAULT,
  parameter int READ_WAIT  = 4,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  busy,
  output logic                  overflow,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ce_n,
  output logic                  mem_read_n,
  output logic                  mem_write_n,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_WORDS - 1);

  state_t            state, next_state;
  logic              accept, abort;
  logic              start_pend;
  logic              cnt_load, cnt_dec, cnt_term;
  logic [WAIT_W-1:0] cnt_val;
  logic              nxt_busy, nxt_ce_n, nxt_write_n;
  logic              unused_ok;

  assign accept = (state == S_IDLE) && byte_valid && enable;
  assign abort  = ((state == S_READ) || (state == S_WRITE)) && !enable;

  fb_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .term     (cnt_term)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
`ifdef PREV_FRAME_EN
          next_state = S_READ;
          cnt_val    = wait_load(READ_WAIT);
`else
          next_state = S_WRITE;
          cnt_val    = wait_load(WRITE_WAIT);
`endif
        end
      end
      S_READ: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (cnt_term) begin
          next_state = S_WRITE;
          cnt_load   = 1'b1;
          cnt_val    = wait_load(WRITE_WAIT);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_WRITE: begin
        if (abort)         next_state = S_IDLE;
        else if (cnt_term) next_state = S_NEXT;
        else               cnt_dec    = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state and registered, so they align with it.
  always_comb begin
    nxt_busy    = (next_state != S_IDLE);
    nxt_ce_n    = STROBE_OFF;
    nxt_write_n = STROBE_OFF;
    case (next_state)
      S_READ:  nxt_ce_n = STROBE_ON;
      S_WRITE: begin
        nxt_ce_n    = STROBE_ON;
        nxt_write_n = STROBE_ON;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      mem_ce_n    <= STROBE_OFF;
      mem_write_n <= STROBE_OFF;
    end else begin
      busy        <= nxt_busy;
      mem_ce_n    <= nxt_ce_n;
      mem_write_n <= nxt_write_n;
    end
  end

`ifdef PREV_FRAME_EN
  logic [7:0] byte_q;

  always_ff @(posedge clk) begin
    if (rst) mem_read_n <= STROBE_OFF;
    else     mem_read_n <= (next_state == S_READ) ? STROBE_ON : STROBE_OFF;
  end

  always_ff @(posedge clk) begin
    if (accept) byte_q <= byte_data;
  end

  assign unused_ok = ^mem_rdata[15:8];
`else
  assign mem_read_n = STROBE_OFF;
  assign unused_ok  = ^{mem_rdata, wait_load(READ_WAIT)};
`endif

  // Address, sticky overflow, deferred start and write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr   <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
      start_pend <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          mem_addr <= '0;
          overflow <= 1'b0;
        end
`ifndef PREV_FRAME_EN
        if (accept) mem_wdata <= {8'h00, byte_data};
`endif
      end else begin
        if (byte_valid) overflow   <= 1'b1;
        if (start)      start_pend <= 1'b1;
      end
`ifdef PREV_FRAME_EN
      if ((state == S_READ) && cnt_term && enable) mem_wdata <= {mem_rdata[7:0], byte_q};
`endif
      if (abort) begin
        overflow   <= 1'b1;
        start_pend <= 1'b0;
        if (start_pend || start) mem_addr <= '0;
      end
      if (state == S_NEXT) begin
        start_pend <= 1'b0;
        if (start_pend || start)       mem_addr <= '0;
        else if (mem_addr == LAST_ADDR) mem_addr <= '0;
        else                           mem_addr <= mem_addr + ADDR_WIDTH'(1);
        if (mem_addr == LAST_ADDR) frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_byte_writer.sv
// Randomized bench for fb_byte_writer against a word-level framebuffer model.
module tb_fb_byte_writer;

  localparam int AW    = 18;
  localparam int TB_FB = 8;
  localparam int RW    = 4;
  localparam int WW    = 2;
`ifdef PREV_FRAME_EN
  localparam bit PREV = 1'b1;
`else
  localparam bit PREV = 1'b0;
`endif
  localparam int BUSY_EXP = PREV ? (RW + WW + 1) : (WW + 1);

  logic          clk, rst, enable, start, byte_valid;
  logic [7:0]    byte_data;
  logic          busy, overflow, frame_done;
  logic [AW-1:0] mem_addr;
  logic          mem_ce_n, mem_read_n, mem_write_n;
  logic [15:0]   mem_wdata, mem_rdata;

  fb_byte_writer #(.ADDR_WIDTH(AW), .FB_WORDS(TB_FB), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .busy(busy), .overflow(overflow), .frame_done(frame_done),
    .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_read_n(mem_read_n),
    .mem_write_n(mem_write_n), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM: combinational read, write while ce_n and write_n are low.
  logic [15:0] mem      [TB_FB];
  logic [15:0] init_mem [TB_FB];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TB_FB; i++) mem[i] <= init_mem[i];
    end else if (!mem_ce_n && !mem_write_n) begin
      mem[mem_addr[2:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[2:0]];

  int rd_low_total = 0, wr_low_total = 0, fd_total = 0, overlap_total = 0;
  always @(negedge clk) begin
    if (!mem_read_n) rd_low_total++;
    if (!mem_write_n) wr_low_total++;
    if (frame_done) fd_total++;
    if (!mem_read_n && !mem_write_n) overlap_total++;
  end

  int          checks = 0, failures = 0;
  logic [15:0] exp_mem [TB_FB];
  int          exp_addr;
  logic        exp_ovf;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [7:0] b);
    exp_mem[exp_addr] = PREV ? {exp_mem[exp_addr][7:0], b} : {8'h00, b};
    exp_addr = (exp_addr == TB_FB - 1) ? 0 : exp_addr + 1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int n);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
    wait_idle(n);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = 0;
    exp_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < TB_FB; i++) init_mem[i] = 16'($urandom);
    init_mem[0] = 16'h1234;
    for (int i = 0; i < TB_FB; i++) exp_mem[i] = init_mem[i];
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, overflow, frame_done, mem_ce_n, mem_read_n, mem_write_n} !== 6'b000111) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000111",
               {busy, overflow, frame_done, mem_ce_n, mem_read_n, mem_write_n});
    end
    checks++;
    if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    checks++;
    if (mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0000", mem_wdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n, r0, w0;
    enable = 1'b1;
    pulse_start();
    r0 = rd_low_total; w0 = wr_low_total;
    send_byte(8'hA5, n);
    model_write(8'hA5);
    tick();
    checks++;
    if (mem[0] !== exp_mem[0]) begin failures++; $display("FAIL single_word got=%h exp=%h", mem[0], exp_mem[0]); end
    checks++;
    if (n != BUSY_EXP) begin failures++; $display("FAIL single_busy got=%0d exp=%0d", n, BUSY_EXP); end
    checks++;
    if (mem_addr !== AW'(exp_addr)) begin failures++; $display("FAIL single_addr got=%0d exp=%0d", mem_addr, exp_addr); end
    checks++;
    if ((rd_low_total - r0) != (PREV ? RW : 0)) begin
      failures++; $display("FAIL single_read_cycles got=%0d exp=%0d", rd_low_total - r0, PREV ? RW : 0);
    end
    checks++;
    if ((wr_low_total - w0) != WW) begin
      failures++; $display("FAIL single_write_cycles got=%0d exp=%0d", wr_low_total - w0, WW);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5];
    int n;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    bytes[3] = 8'($urandom); bytes[4] = 8'($urandom);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i], n);
      model_write(bytes[i]);
      checks++;
      if (n != BUSY_EXP) begin failures++; $display("FAIL b2b_busy[%0d] got=%0d exp=%0d", i, n, BUSY_EXP); end
    end
    for (int i = 0; i < TB_FB; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL b2b_word[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]); end
    end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
    checks++;
    if (mem_addr !== AW'(exp_addr)) begin failures++; $display("FAIL b2b_addr got=%0d exp=%0d", mem_addr, exp_addr); end
  endtask

  task automatic test_overflow();
    logic [7:0] b1, b2;
    int n;
    b1 = 8'($urandom); b2 = ~b1;
    byte_valid = 1'b1; byte_data = b1;
    tick();
    byte_valid = 1'b0;
    tick();
    byte_valid = 1'b1; byte_data = b2;
    tick();
    byte_valid = 1'b0;
    wait_idle(n);
    model_write(b1);
    exp_ovf = 1'b1;
    checks++;
    if (overflow !== exp_ovf) begin failures++; $display("FAIL ovf_set got=%b exp=%b", overflow, exp_ovf); end
    checks++;
    if (mem_addr !== AW'(exp_addr)) begin failures++; $display("FAIL ovf_addr got=%0d exp=%0d", mem_addr, exp_addr); end
    for (int i = 0; i < TB_FB; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL ovf_word[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]); end
    end
    pulse_start();
    checks++;
    if (overflow !== exp_ovf) begin failures++; $display("FAIL ovf_clear got=%b exp=%b", overflow, exp_ovf); end
    checks++;
    if (mem_addr !== AW'(exp_addr)) begin failures++; $display("FAIL start_addr got=%0d exp=%0d", mem_addr, exp_addr); end
  endtask

  task automatic test_enable_low();
    enable = 1'b0;
    byte_valid = 1'b1; byte_data = 8'($urandom);
    tick();
    byte_valid = 1'b0;
    tick();
    checks++;
    if ({busy, overflow} !== {1'b0, exp_ovf}) begin
      failures++; $display("FAIL drawing_ignore got=%b%b exp=0%b", busy, overflow, exp_ovf);
    end
    checks++;
    if (mem_addr !== AW'(exp_addr)) begin failures++; $display("FAIL drawing_addr got=%0d exp=%0d", mem_addr, exp_addr); end
    enable = 1'b1;
  endtask

  task automatic test_abort();
    logic [7:0] b;
    int r0, w0;
    b = 8'($urandom);
    r0 = rd_low_total; w0 = wr_low_total;
    byte_valid = 1'b1; byte_data = b;
    tick();
    byte_valid = 1'b0;
    if (PREV) tick();
    enable = 1'b0;
    tick();
    if (!PREV) exp_mem[exp_addr] = {8'h00, b};
    exp_ovf = 1'b1;
    checks++;
    if ({busy, mem_ce_n, mem_read_n, mem_write_n} !== 4'b0111) begin
      failures++; $display("FAIL abort_strobes got=%b exp=0111", {busy, mem_ce_n, mem_read_n, mem_write_n});
    end
    checks++;
    if (overflow !== exp_ovf) begin failures++; $display("FAIL abort_ovf got=%b exp=%b", overflow, exp_ovf); end
    checks++;
    if (mem_addr !== AW'(exp_addr)) begin failures++; $display("FAIL abort_addr got=%0d exp=%0d", mem_addr, exp_addr); end
    checks++;
    if ((wr_low_total - w0) != (PREV ? 0 : 1)) begin
      failures++; $display("FAIL abort_write_cycles got=%0d exp=%0d", wr_low_total - w0, PREV ? 0 : 1);
    end
    checks++;
    if ((rd_low_total - r0) != (PREV ? 2 : 0)) begin
      failures++; $display("FAIL abort_read_cycles got=%0d exp=%0d", rd_low_total - r0, PREV ? 2 : 0);
    end
    tick();
    checks++;
    if (mem[exp_addr] !== exp_mem[exp_addr]) begin
      failures++; $display("FAIL abort_word got=%h exp=%h", mem[exp_addr], exp_mem[exp_addr]);
    end
    enable = 1'b1;
  endtask

  task automatic test_wrap();
    int n, f0;
    logic [7:0] b;
    pulse_start();
    f0 = fd_total;
    for (int i = 0; i < TB_FB - 1; i++) begin
      b = 8'($urandom);
      send_byte(b, n);
      model_write(b);
    end
    checks++;
    if (fd_total != f0) begin failures++; $display("FAIL wrap_early_done got=%0d exp=%0d", fd_total - f0, 0); end
    checks++;
    if (mem_addr !== AW'(TB_FB - 1)) begin failures++; $display("FAIL wrap_last_addr got=%0d exp=%0d", mem_addr, TB_FB - 1); end
    f0 = fd_total;
    send_byte(8'hFF, n);
    model_write(8'hFF);
    checks++;
    if (frame_done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b exp=1", frame_done); end
    checks++;
    if (mem_addr !== AW'(exp_addr)) begin failures++; $display("FAIL wrap_addr got=%0d exp=%0d", mem_addr, exp_addr); end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("FAIL wrap_done_pulse got=%b exp=0", frame_done); end
    tick();
    checks++;
    if (fd_total - f0 != 1) begin failures++; $display("FAIL wrap_done_count got=%0d exp=1", fd_total - f0); end
    checks++;
    if (mem[TB_FB-1] !== exp_mem[TB_FB-1]) begin
      failures++; $display("FAIL wrap_word got=%h exp=%h", mem[TB_FB-1], exp_mem[TB_FB-1]);
    end
  endtask

  task automatic test_start_with_byte();
    int n;
    logic [7:0] b;
    b = 8'($urandom);
    send_byte(b, n);
    model_write(b);
    b = 8'($urandom);
    start = 1'b1; byte_valid = 1'b1; byte_data = b;
    tick();
    start = 1'b0; byte_valid = 1'b0;
    exp_addr = 0; exp_ovf = 1'b0;
    wait_idle(n);
    model_write(b);
    checks++;
    if (mem[0] !== exp_mem[0]) begin failures++; $display("FAIL start_byte_word got=%h exp=%h", mem[0], exp_mem[0]); end
    checks++;
    if (mem_addr !== AW'(exp_addr)) begin failures++; $display("FAIL start_byte_addr got=%0d exp=%0d", mem_addr, exp_addr); end
    checks++;
    if (overflow !== exp_ovf) begin failures++; $display("FAIL start_byte_ovf got=%b exp=%b", overflow, exp_ovf); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    exp_addr = 0; exp_ovf = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_enable_low();
    test_abort();
    test_wrap();
    test_start_with_byte();
    checks++;
    if (overlap_total != 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", overlap_total); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
